// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types and constants for the serial magnitude comparator:
// FSM state encoding, one-hot result codes and the slice-counter sizing helper.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  // Result vector layout is {gt, lt, eq}
  localparam logic [2:0] RES_EQ = 3'b001;
  localparam logic [2:0] RES_LT = 3'b010;
  localparam logic [2:0] RES_GT = 3'b100;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Producer/consumer handshake bundle for serial_magnitude_comparator.
// signed_mode exists only when SERIAL_CMP_SIGNED_EN is defined.
interface serial_magnitude_comparator_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_CMP_SIGNED_EN
  logic             signed_mode;
`endif
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic             lt;
  logic             gt;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
`ifdef SERIAL_CMP_SIGNED_EN
    output signed_mode,
`endif
    input  in_ready, out_valid, eq, lt, gt, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
`ifdef SERIAL_CMP_SIGNED_EN
    input  signed_mode,
`endif
    output in_ready, out_valid, eq, lt, gt, busy
  );
endinterface

// File: rtl/serial_magnitude_comparator_digit_cmp.sv
// Combinational DIGIT-bit slice comparer; exactly one of the three outputs is high.
module digit_cmp #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] x_i,
  input  logic [DIGIT-1:0] y_i,
  output logic             slice_eq,
  output logic             slice_lt,
  output logic             slice_gt
);
  always_comb begin
    slice_eq = (x_i == y_i);
    slice_lt = (x_i <  y_i);
    slice_gt = (x_i >  y_i);
  end
endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle with early exit.
// Optional signed compare enabled by defining SERIAL_CMP_SIGNED_EN.
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  serial_magnitude_comparator_if.slave  bus
);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_range
    $error("serial_magnitude_comparator: DIGIT must satisfy 1 <= DIGIT <= WIDTH");
  end else if ((WIDTH % DIGIT) != 0) begin : g_bad_div
    $error("serial_magnitude_comparator: WIDTH must be a multiple of DIGIT");
  end

  localparam int unsigned NSLICE = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
  localparam int unsigned CW     = cnt_width(NSLICE);
  localparam logic [CW-1:0]    LAST_SLICE = CW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] MSB_MASK   = WIDTH'(1) << (WIDTH - 1);

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       res_q, res_d;

  logic             sm;
  logic [WIDTH-1:0] flip;
  logic             s_eq, s_lt, s_gt;
  logic             in_ready, out_valid, busy;

`ifdef SERIAL_CMP_SIGNED_EN
  assign sm = bus.signed_mode;
`else
  assign sm = 1'b0;
`endif

  // Inverting both MSBs maps two's complement ordering onto unsigned ordering
  assign flip = sm ? MSB_MASK : '0;

  digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
    .x_i      (a_q[WIDTH-1 -: DIGIT]),
    .y_i      (b_q[WIDTH-1 -: DIGIT]),
    .slice_eq (s_eq),
    .slice_lt (s_lt),
    .slice_gt (s_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a ^ flip;
          b_d     = bus.b ^ flip;
          cnt_d   = '0;
          state_d = CMP;
        end
      end
      CMP: begin
        if (!s_eq) begin
          res_d   = (s_lt ? RES_LT : '0) | (s_gt ? RES_GT : '0);
          state_d = DONE;
        end else if (cnt_q == LAST_SLICE) begin
          res_d   = RES_EQ;
          state_d = DONE;
        end else begin
          a_d   = a_q << DIGIT;
          b_d   = b_q << DIGIT;
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          res_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.eq        = res_q[0];
  assign bus.lt        = res_q[1];
  assign bus.gt        = res_q[2];

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator: 16/4 main instance plus 8/{1,2,8} sweep.
// Signed cases run only when SERIAL_CMP_SIGNED_EN is defined.
module tb_serial_magnitude_comparator;

  localparam logic [2:0] E_EQ = 3'b001;
  localparam logic [2:0] E_LT = 3'b010;
  localparam logic [2:0] E_GT = 3'b100;
`ifdef SERIAL_CMP_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_magnitude_comparator_if #(.WIDTH(16)) m ();

  serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m)
  );

  logic [7:0] sw_a, sw_b;
  logic       sw_v, sw_rdy, sw_sm;
  logic [2:0] sw_ov, sw_ir;
  logic [2:0] sw_res [3];

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int unsigned D = (g == 0) ? 1 : (g == 1) ? 2 : 8;
    serial_magnitude_comparator_if #(.WIDTH(8)) s ();
    assign s.in_valid  = sw_v;
    assign s.a         = sw_a;
    assign s.b         = sw_b;
    assign s.out_ready = sw_rdy;
`ifdef SERIAL_CMP_SIGNED_EN
    assign s.signed_mode = sw_sm;
`endif
    assign sw_ov[g]  = s.out_valid;
    assign sw_ir[g]  = s.in_ready;
    assign sw_res[g] = {s.gt, s.lt, s.eq};
    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(D)) u_sw (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (s)
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] main_res();
    return {m.gt, m.lt, m.eq};
  endfunction

  // Full transaction on the 16/4 instance; a/b are scrambled right after acceptance.
  task automatic run_main(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] exp_res, input int unsigned exp_lat);
    int unsigned lat;
    m.a = a; m.b = b; m.in_valid = 1'b1; m.out_ready = 1'b0;
    check({tag, " in_ready"}, 32'(m.in_ready), 32'd1);
    @(posedge clk); #1;
    m.in_valid = 1'b0; m.a = ~a; m.b = ~b;
    lat = 0;
    while (m.out_valid !== 1'b1 && lat < 20) begin
      check({tag, " busy"}, 32'(m.busy), 32'd1);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, 32'(main_res()), 32'(exp_res));
    check({tag, " in_ready done"}, 32'(m.in_ready), 32'd0);
    m.out_ready = 1'b1;
    @(posedge clk); #1;
    m.out_ready = 1'b0;
    check({tag, " cleared"}, 32'({m.out_valid, main_res()}), 32'd0);
    check({tag, " idle"}, 32'(m.in_ready), 32'd1);
  endtask

  function automatic logic [2:0] model_res(input logic [7:0] a, input logic [7:0] b, input logic sm);
    if (sm && SIGNED_BUILD)
      return ($signed(a) < $signed(b)) ? E_LT : ($signed(a) > $signed(b)) ? E_GT : E_EQ;
    return (a < b) ? E_LT : (a > b) ? E_GT : E_EQ;
  endfunction

  function automatic int unsigned model_lat(input logic [7:0] a, input logic [7:0] b, input int unsigned d);
    logic [7:0] x, t;
    x = a ^ b;
    for (int unsigned i = 0; i < 8 / d; i++) begin
      t = x << (i * d);
      t = t >> (8 - d);
      if (t != 8'd0) return i + 1;
    end
    return 8 / d;
  endfunction

  // One pair presented to the three 8-bit instances in parallel.
  task automatic sweep(input logic [7:0] a, input logic [7:0] b, input logic sm);
    int unsigned lat [3];
    logic [2:0]  got [3];
    int unsigned dg  [3];
    dg = '{1, 2, 8};
    for (int k = 0; k < 3; k++) begin lat[k] = 0; got[k] = '0; end
    sw_a = a; sw_b = b; sw_sm = sm; sw_v = 1'b1;
    check("sw in_ready", 32'(sw_ir), 32'h7);
    @(posedge clk); #1;
    sw_v = 1'b0; sw_a = ~a; sw_b = ~b;
    for (int unsigned c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++)
        if (lat[k] == 0 && sw_ov[k]) begin lat[k] = c; got[k] = sw_res[k]; end
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sw d%0d %h/%h lat", dg[k], a, b), lat[k], model_lat(a, b, dg[k]));
      check($sformatf("sw d%0d %h/%h res", dg[k], a, b), 32'(got[k]), 32'(model_res(a, b, sm)));
      check($sformatf("sw d%0d %h/%h held", dg[k], a, b), 32'(sw_res[k]), 32'(model_res(a, b, sm)));
    end
    sw_rdy = 1'b1;
    @(posedge clk); #1;
    sw_rdy = 1'b0;
    check("sw released", 32'(sw_ov), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    m.in_valid = 1'b0; m.out_ready = 1'b0; m.a = '0; m.b = '0;
`ifdef SERIAL_CMP_SIGNED_EN
    m.signed_mode = 1'b0;
`endif
    sw_a = '0; sw_b = '0; sw_v = 1'b0; sw_rdy = 1'b0; sw_sm = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset in_ready", 32'(m.in_ready), 32'd1);
    check("reset out_valid", 32'(m.out_valid), 32'd0);
    check("reset result", 32'(main_res()), 32'd0);
    check("reset busy", 32'(m.busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_main("eq1234", 16'h1234, 16'h1234, E_EQ, 4);
    run_main("gt8000", 16'h8000, 16'h7FFF, E_GT, 1);
    run_main("lt00F0", 16'h00F0, 16'h00F1, E_LT, 4);
    run_main("lt0000", 16'h0000, 16'hFFFF, E_LT, 1);
    run_main("gt1243", 16'h1243, 16'h1234, E_GT, 3);
    run_main("eqFFFF", 16'hFFFF, 16'hFFFF, E_EQ, 4);

    // Back-pressure in DONE with new operands waiting
    m.a = 16'h0005; m.b = 16'h0003; m.in_valid = 1'b1;
    @(posedge clk); #1;
    m.in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("bp valid", 32'(m.out_valid), 32'd1);
    check("bp result", 32'(main_res()), 32'(E_GT));
    m.a = 16'h0001; m.b = 16'h0002; m.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp hold valid", 32'(m.out_valid), 32'd1);
      check("bp hold result", 32'(main_res()), 32'(E_GT));
      check("bp hold in_ready", 32'(m.in_ready), 32'd0);
    end
    m.out_ready = 1'b1;
    @(posedge clk); #1;
    m.out_ready = 1'b0;
    check("bp release in_ready", 32'(m.in_ready), 32'd1);
    check("bp release cleared", 32'({m.out_valid, main_res()}), 32'd0);
    @(posedge clk); #1;
    m.in_valid = 1'b0;
    check("bp recapture busy", 32'(m.busy), 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    check("bp second pending", 32'(m.out_valid), 32'd0);
    @(posedge clk); #1;
    check("bp second valid", 32'(m.out_valid), 32'd1);
    check("bp second result", 32'(main_res()), 32'(E_LT));
    m.out_ready = 1'b1;
    @(posedge clk); #1;
    m.out_ready = 1'b0;

    // Asynchronous reset while slice 2 is being compared
    m.a = 16'h1234; m.b = 16'h1235; m.in_valid = 1'b1;
    @(posedge clk); #1;
    m.in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst mid busy", 32'(m.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst mid out_valid", 32'(m.out_valid), 32'd0);
    check("rst mid result", 32'(main_res()), 32'd0);
    check("rst mid in_ready", 32'(m.in_ready), 32'd1);
    check("rst mid busy clr", 32'(m.busy), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_main("post-rst", 16'h4321, 16'h1234, E_GT, 1);

`ifdef SERIAL_CMP_SIGNED_EN
    m.signed_mode = 1'b1;
    run_main("s8000<1", 16'h8000, 16'h0001, E_LT, 1);
    run_main("sFFFF<1", 16'hFFFF, 16'h0001, E_LT, 1);
    m.signed_mode = 1'b0;
    run_main("u8000>1", 16'h8000, 16'h0001, E_GT, 1);
`endif

    sweep(8'h00, 8'h00, 1'b0);
    sweep(8'hFF, 8'h00, 1'b0);
    sweep(8'h80, 8'h7F, 1'b1);
    sweep(8'h12, 8'h13, 1'b0);
    sweep(8'hA5, 8'hA5, 1'b1);
    for (int i = 0; i < 8; i++)
      sweep(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
